mem_stage: RTL and testbench

- Memory-access pipeline stage, directly downstream of the execute stage and upstream of write-back.
- Registers the execute-to-memory bus and takes read data from the synchronous data SRAM. The SRAM was addressed by the execute stage in the previous cycle.
- Extracts and extends byte, halfword and word loads, then selects the register-file write data.
- Drives the memory-to-write-back bus and a forwarding bus back to decode.
- Preserves load data across pipeline stalls.

---
 rtl/mem_stage_if.sv | 42 ++++
 rtl/mem_stage.sv | 105 ++++++++++
 tb/tb_mem_stage.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
//   Bus bundle around the memory-access pipeline stage.
//
//   Signals:
//     stall           6              pipeline stall vector (1 = Stop), monotonic
//     ex_to_mem_bus   EX_TO_MEM_WD   registered execute-to-memory bus
//     data_sram_rdata 32             synchronous data SRAM read word
//     mem_to_wb_bus   MEM_TO_WB_WD   {pc, rf_we, rf_waddr, rf_wdata} to write-back
//     mem_to_id_bus   MEM_TO_ID_WD   {rf_we, rf_waddr, rf_wdata} forwarded to decode
//
//   Modports:
//     master - upstream/environment side (drives stall, bus, rdata)
//     slave  - the mem_stage itself
// -----------------------------------------------------------------------------
interface mem_stage_if #(
    parameter int EX_TO_MEM_WD = 79,
    parameter int MEM_TO_WB_WD = 70,
    parameter int MEM_TO_ID_WD = 38
);
    logic [5:0]              stall;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [31:0]             data_sram_rdata;
    logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
    logic [MEM_TO_ID_WD-1:0] mem_to_id_bus;

    modport master (
        output stall,
        output ex_to_mem_bus,
        output data_sram_rdata,
        input  mem_to_wb_bus,
        input  mem_to_id_bus
    );

    modport slave (
        input  stall,
        input  ex_to_mem_bus,
        input  data_sram_rdata,
        output mem_to_wb_bus,
        output mem_to_id_bus
    );
endinterface

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory-access pipeline stage between execute and write-back. Registers the
//   execute-to-memory bus, takes the synchronous SRAM read word (addressed by
//   execute one cycle earlier), extracts/extends byte, halfword and word loads
//   and selects the register-file write data. The first-cycle read word is
//   held while the entry is stalled, since the SRAM output may move on.
//
//   Ports:
//     clk     clock
//     rst     synchronous, active-high reset
//     bus_if  mem_stage_if.slave: stall, ex_to_mem_bus, data_sram_rdata in;
//             mem_to_wb_bus, mem_to_id_bus out (both combinational from the
//             stage register and the effective read word)
// -----------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus_if
);

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  mem_op;
        logic        data_ram_en;
        logic [3:0]  data_ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    ex_to_mem_t  bus_r;
    logic [31:0] rdata_hold;
    logic        hold_valid;
    logic [31:0] rdata_eff;
    logic [31:0] load_res;
    logic [31:0] rf_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        bubble;
    logic        hold_stall;

    // Execute is stopped but memory may advance: push a bubble downstream.
    assign bubble     = bus_if.stall[3] & ~bus_if.stall[4];
    // This stage itself is frozen with its current entry.
    assign hold_stall = bus_if.stall[3] &  bus_if.stall[4];

    // NOTE: clocked state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            bus_r <= '0;
        end else if (!bus_if.stall[3]) begin
            bus_r <= ex_to_mem_t'(bus_if.ex_to_mem_bus);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !hold_stall) begin
            hold_valid <= 1'b0;
        end else if (!hold_valid) begin
            hold_valid <= 1'b1;
        end
    end

    // NOTE: rdata_hold is a pure data register with no reset; it is only ever
    // observed while hold_valid is set, and hold_valid is reset.
    always_ff @(posedge clk) begin
        if (!rst && hold_stall && !hold_valid) begin
            rdata_hold <= bus_if.data_sram_rdata;
        end
    end

    // First cycle in the stage uses the live SRAM word; later stalled cycles
    // replay the captured copy.
    assign rdata_eff = hold_valid ? rdata_hold : bus_if.data_sram_rdata;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        ld_byte  = rdata_eff[{bus_r.ex_result[1:0], 3'b000} +: 8];
        ld_half  = bus_r.ex_result[1] ? rdata_eff[31:16] : rdata_eff[15:0];
        load_res = '0;
        case (bus_r.mem_op)
            3'b001:                load_res = {{24{ld_byte[7]}}, ld_byte};
            3'b010:                load_res = {24'b0, ld_byte};
            3'b011:                load_res = {{16{ld_half[15]}}, ld_half};
            3'b100:                load_res = {16'b0, ld_half};
            3'b101, 3'b110, 3'b111: load_res = rdata_eff;
            default:               load_res = '0;
        endcase
    end

    assign rf_wdata = bus_r.sel_rf_res ? load_res : bus_r.ex_result;

    assign bus_if.mem_to_wb_bus = {bus_r.pc, bus_r.rf_we, bus_r.rf_waddr, rf_wdata};
    assign bus_if.mem_to_id_bus = {bus_r.rf_we, bus_r.rf_waddr, rf_wdata};

    // Store controls and the other stall bits have no role in this stage.
    logic unused_bits;
    assign unused_bits = ^{bus_r.data_ram_en, bus_r.data_ram_wen,
                           bus_if.stall[5], bus_if.stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//   Self-checking bench for mem_stage: directed literal checks followed by a
//   randomized run compared every cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_stage_if bus_if ();

    mem_stage dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus_if)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_en   = 1'b0;

    // Behavioural model: the entry in the stage, how many cycles it has been
    // there, and the SRAM word seen during its first cycle.
    logic [78:0] m_entry = '0;
    int          m_age   = 0;
    logic [31:0] m_first = '0;

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [78:0] mk(input logic [31:0] pc, input logic [2:0] op,
                                       input logic sel, input logic we,
                                       input logic [4:0] waddr, input logic [31:0] res);
        return {pc, op, 1'b0, 4'b0, sel, we, waddr, res};
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (op)
            3'd1: return (b >= 32'd128) ? b - 32'd256 : b;
            3'd2: return b;
            3'd3: return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4: return h;
            3'd5, 3'd6, 3'd7: return w;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [69:0] exp_wb(input logic [78:0] e, input int age,
                                           input logic [31:0] first, input logic [31:0] live);
        logic [31:0] word;
        logic [31:0] wd;
        word = (age == 0) ? live : first;
        wd   = e[38] ? load_val(e[46:44], e[1:0], word) : e[31:0];
        return {e[78:47], e[37], e[36:32], wd};
    endfunction

    // Model update on the active edge from the inputs that were stable before it.
    always @(posedge clk) begin
        if (m_age == 0) m_first <= bus_if.data_sram_rdata;
        if (rst) begin
            m_entry <= '0;
            m_age   <= 0;
            cmp_en  <= 1'b1;
        end else if (!bus_if.stall[3]) begin
            m_entry <= bus_if.ex_to_mem_bus;
            m_age   <= 0;
        end else if (!bus_if.stall[4]) begin
            m_entry <= '0;
            m_age   <= 0;
        end else if (m_age < 1000) begin
            m_age   <= m_age + 1;
        end
    end

    // Compare process: outputs sampled on the inactive edge.
    always @(negedge clk) begin
        logic [69:0] e;
        if (cmp_en) begin
            e = exp_wb(m_entry, m_age, m_first, bus_if.data_sram_rdata);
            check("model_wb", bus_if.mem_to_wb_bus, e);
            check("model_id", {32'b0, bus_if.mem_to_id_bus}, {32'b0, e[37:0]});
        end
    end

    task automatic load_check(input string name, input logic [2:0] op, input logic [1:0] a,
                              input logic [31:0] w, input logic [31:0] exp);
        bus_if.ex_to_mem_bus = mk(32'h8000_0000, op, 1'b1, 1'b1, 5'd7, {30'h40, a});
        bus_if.stall         = 6'b0;
        @(posedge clk); #1;
        bus_if.ex_to_mem_bus   = '0;
        bus_if.data_sram_rdata = w;
        @(negedge clk);
        check(name, {38'b0, bus_if.mem_to_wb_bus[31:0]}, {38'b0, exp});
    endtask

    initial begin
        bus_if.stall           = 6'b0;
        bus_if.ex_to_mem_bus   = '0;
        bus_if.data_sram_rdata = '0;
        rst                    = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_wb", bus_if.mem_to_wb_bus, 70'd0);
        check("reset_id", {32'b0, bus_if.mem_to_id_bus}, 70'd0);

        // Plain ALU result passes straight through
        rst = 1'b0;
        bus_if.ex_to_mem_bus = mk(32'hBFC0_0000, 3'b000, 1'b0, 1'b1, 5'd5, 32'h1234);
        @(posedge clk); #1;
        bus_if.ex_to_mem_bus = '0;
        @(negedge clk);
        check("alu_wb", bus_if.mem_to_wb_bus, {32'hBFC0_0000, 1'b1, 5'd5, 32'h0000_1234});
        check("alu_id", {32'b0, bus_if.mem_to_id_bus}, {32'b0, 1'b1, 5'd5, 32'h0000_1234});

        // Byte / halfword / word extraction
        load_check("lb_a3",  3'b001, 2'd3, 32'h80FF_7F01, 32'hFFFF_FF80);
        load_check("lbu_a3", 3'b010, 2'd3, 32'h80FF_7F01, 32'h0000_0080);
        load_check("lb_a1",  3'b001, 2'd1, 32'h80FF_7F01, 32'h0000_007F);
        load_check("lb_a0",  3'b001, 2'd0, 32'h80FF_7F01, 32'h0000_0001);
        load_check("lh_a2",  3'b011, 2'd2, 32'h8001_ABCD, 32'hFFFF_8001);
        load_check("lhu_a0", 3'b100, 2'd0, 32'h8001_ABCD, 32'h0000_ABCD);
        load_check("lh_a1",  3'b011, 2'd1, 32'h8001_ABCD, 32'hFFFF_ABCD);
        load_check("lw_a2",  3'b101, 2'd2, 32'h8001_ABCD, 32'h8001_ABCD);
        load_check("lw_op6", 3'b110, 2'd1, 32'h1357_9BDF, 32'h1357_9BDF);
        load_check("op0",    3'b000, 2'd0, 32'h1357_9BDF, 32'h0000_0000);

        // Stalled lw keeps its first-cycle word
        bus_if.ex_to_mem_bus = mk(32'h8000_0100, 3'b101, 1'b1, 1'b1, 5'd9, 32'h100);
        bus_if.stall         = 6'b0;
        @(posedge clk); #1;
        bus_if.ex_to_mem_bus   = mk(32'h8000_0104, 3'b111, 1'b1, 1'b1, 5'd10, 32'h104);
        bus_if.data_sram_rdata = 32'hDEAD_BEEF;
        bus_if.stall           = 6'b011111;
        @(negedge clk);
        check("stall_c0", {38'b0, bus_if.mem_to_wb_bus[31:0]}, {38'b0, 32'hDEAD_BEEF});
        @(posedge clk); #1;
        bus_if.data_sram_rdata = 32'h0;
        @(negedge clk);
        check("stall_c1", {38'b0, bus_if.mem_to_wb_bus[31:0]}, {38'b0, 32'hDEAD_BEEF});
        @(posedge clk); #1;
        bus_if.data_sram_rdata = 32'h5555_5555;
        @(negedge clk);
        check("stall_c2", {38'b0, bus_if.mem_to_wb_bus[31:0]}, {38'b0, 32'hDEAD_BEEF});
        @(posedge clk); #1;
        bus_if.stall = 6'b0;
        @(negedge clk);
        check("stall_c3", {38'b0, bus_if.mem_to_wb_bus[31:0]}, {38'b0, 32'hDEAD_BEEF});
        @(posedge clk); #1;
        bus_if.ex_to_mem_bus   = '0;
        bus_if.data_sram_rdata = 32'h1111_2222;
        @(negedge clk);
        check("after_stall_data",  {38'b0, bus_if.mem_to_wb_bus[31:0]}, {38'b0, 32'h1111_2222});
        check("after_stall_waddr", {65'b0, bus_if.mem_to_wb_bus[36:32]}, {65'b0, 5'd10});

        // Bubble insert
        bus_if.ex_to_mem_bus = mk(32'h8000_0200, 3'b000, 1'b0, 1'b1, 5'd3, 32'h77);
        @(posedge clk); #1;
        bus_if.stall         = 6'b001111;
        bus_if.ex_to_mem_bus = mk(32'h8000_0204, 3'b101, 1'b1, 1'b1, 5'd4, 32'h88);
        @(negedge clk);
        check("pre_bubble", {38'b0, bus_if.mem_to_wb_bus[31:0]}, {38'b0, 32'h0000_0077});
        @(posedge clk); #1;
        bus_if.stall         = 6'b0;
        bus_if.ex_to_mem_bus = '0;
        @(negedge clk);
        check("bubble_wb", bus_if.mem_to_wb_bus, 70'd0);
        check("bubble_id", {32'b0, bus_if.mem_to_id_bus}, 70'd0);

        // Reset during a held lw
        bus_if.ex_to_mem_bus = mk(32'h8000_0300, 3'b101, 1'b1, 1'b1, 5'd4, 32'h200);
        @(posedge clk); #1;
        bus_if.data_sram_rdata = 32'hCAFE_F00D;
        bus_if.stall           = 6'b011111;
        @(posedge clk); #1;
        bus_if.data_sram_rdata = 32'h0;
        rst = 1'b1;
        @(negedge clk);
        check("held_before_rst", {38'b0, bus_if.mem_to_wb_bus[31:0]}, {38'b0, 32'hCAFE_F00D});
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid_wb", bus_if.mem_to_wb_bus, 70'd0);
        check("rst_mid_id", {32'b0, bus_if.mem_to_id_bus}, 70'd0);
        rst                  = 1'b0;
        bus_if.stall         = 6'b0;
        bus_if.ex_to_mem_bus = mk(32'h8000_0400, 3'b101, 1'b1, 1'b1, 5'd6, 32'h300);
        @(posedge clk); #1;
        bus_if.ex_to_mem_bus   = '0;
        bus_if.data_sram_rdata = 32'h0BAD_C0DE;
        @(negedge clk);
        check("fresh_after_rst", {38'b0, bus_if.mem_to_wb_bus[31:0]}, {38'b0, 32'h0BAD_C0DE});

        // Randomized run against the model
        repeat (600) begin
            int k;
            @(posedge clk); #1;
            rst = ($urandom_range(0, 40) == 0);
            k   = $urandom_range(0, 6);
            bus_if.stall           = 6'((1 << k) - 1);
            bus_if.ex_to_mem_bus   = 79'({$urandom, $urandom, $urandom});
            bus_if.data_sram_rdata = $urandom;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
